// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Streams a program image, byte by byte, into instruction memory while the
// pipeline core is held in reset, then releases the core.
//
// Stream: 16-bit big-endian word count N, then 4*N bytes with each word sent
// most-significant byte first. A count above the memory capacity is rejected
// and the core stays in reset.
//
// Ports
//   clock       single clock, rising edge
//   reset       asynchronous, active-high
//   start       one-cycle request to begin (or restart) a load
//   in_data     serial program byte
//   in_valid    in_data valid this cycle
//   in_ready    loader accepts a byte this cycle
//   imem_we     instruction-memory write strobe (one cycle per word)
//   imem_addr   word index being written
//   imem_wdata  assembled instruction word
//   cpu_reset   holds the pipeline core in reset while 1
//   busy        load in progress
//   done        load completed, core released
//   error       header rejected, core held
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // Largest legal word count: the full memory, 2^ADDR_W words.
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_t            state_r;
    state_t            next_state_s;
    logic [ADDR_W:0]   word_idx_r;   // one extra bit so N = 2^ADDR_W does not wrap
    logic [1:0]        byte_cnt_r;
    logic [31:0]       asm_r;
    logic [15:0]       len_r;
    logic              xfer_s;
    logic [16:0]       len_full_s;
    logic [16:0]       idx_next_s;
    logic              last_word_s;

    // Handshake and length decode used by the state transitions.
    always_comb begin
        xfer_s      = in_valid & in_ready;
        // The low length byte is still on in_data while in LEN_LO.
        len_full_s  = {1'b0, len_r[15:8], in_data};
        idx_next_s  = 17'(word_idx_r) + 17'd1;
        last_word_s = (idx_next_s == {1'b0, len_r});
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    next_state_s = S_LEN_HI;
                end else begin
                    next_state_s = state_r;
                end
            end
            S_LEN_HI: begin
                if (xfer_s) begin
                    next_state_s = S_LEN_LO;
                end else begin
                    next_state_s = S_LEN_HI;
                end
            end
            S_LEN_LO: begin
                if (!xfer_s) begin
                    next_state_s = S_LEN_LO;
                end else if (len_full_s == 17'd0) begin
                    next_state_s = S_DONE;
                end else if (len_full_s > MAX_WORDS) begin
                    next_state_s = S_ERR;
                end else begin
                    next_state_s = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer_s && (byte_cnt_r == 2'd3)) begin
                    next_state_s = S_WRITE;
                end else begin
                    next_state_s = S_DATA;
                end
            end
            S_WRITE: begin
                if (last_word_s) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_DATA;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register and Moore outputs, registered from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            imem_we   <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            in_ready  <= (next_state_s == S_LEN_HI) || (next_state_s == S_LEN_LO) ||
                         (next_state_s == S_DATA);
            busy      <= (next_state_s == S_LEN_HI) || (next_state_s == S_LEN_LO) ||
                         (next_state_s == S_DATA)   || (next_state_s == S_WRITE);
            cpu_reset <= (next_state_s != S_DONE);
            done      <= (next_state_s == S_DONE);
            error     <= (next_state_s == S_ERR);
            imem_we   <= (next_state_s == S_WRITE);
        end
    end

    // Datapath: length capture, byte assembly, word index, write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_idx_r <= {(ADDR_W+1){1'b0}};
            byte_cnt_r <= 2'd0;
            asm_r      <= 32'd0;
            len_r      <= 16'd0;
            imem_addr  <= {ADDR_W{1'b0}};
            imem_wdata <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        word_idx_r <= {(ADDR_W+1){1'b0}};
                        byte_cnt_r <= 2'd0;
                    end
                end
                S_LEN_HI: begin
                    if (xfer_s) begin
                        len_r[15:8] <= in_data;
                    end
                end
                S_LEN_LO: begin
                    if (xfer_s) begin
                        len_r[7:0] <= in_data;
                    end
                end
                S_DATA: begin
                    if (xfer_s) begin
                        asm_r      <= {asm_r[23:0], in_data};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        // Latch the write port on the 4th byte so the strobe
                        // lands in the very next cycle.
                        if (byte_cnt_r == 2'd3) begin
                            imem_addr  <= word_idx_r[ADDR_W-1:0];
                            imem_wdata <= {asm_r[23:0], in_data};
                        end
                    end
                end
                S_WRITE: begin
                    word_idx_r <= word_idx_r + {{ADDR_W{1'b0}}, 1'b1};
                end
                default: begin
                    byte_cnt_r <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;
    int we_count = 0;
    int we_base  = 0;

    imem_loader #(.ADDR_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts every cycle in which the write strobe is high.
    always @(negedge clock) begin
        if (imem_we === 1'b1) we_count = we_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; returns at the negedge after the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clock);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("ready_wait", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Send one word MSB first and check the write strobe in the following cycle.
    task automatic send_word(input logic [7:0] addr, input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
        check("we_latency", {31'd0, imem_we}, 32'd1);
        check("we_addr",    {24'd0, imem_addr}, {24'd0, addr});
        check("we_data",    imem_wdata, w);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    {31'd0, imem_we},   32'd0);
        check({tag, "_addr"},  {24'd0, imem_addr}, 32'd0);
        check({tag, "_wdata"}, imem_wdata,         32'd0);
        check({tag, "_cpurst"},{31'd0, cpu_reset}, 32'd1);
        check({tag, "_ready"}, {31'd0, in_ready},  32'd0);
        check({tag, "_busy"},  {31'd0, busy},      32'd0);
        check({tag, "_done"},  {31'd0, done},      32'd0);
        check({tag, "_err"},   {31'd0, error},     32'd0);
    endtask

    task automatic check_done(input string tag, input int writes);
        #1;
        check({tag, "_done"},   {31'd0, done},      32'd1);
        check({tag, "_cpurst"}, {31'd0, cpu_reset}, 32'd0);
        check({tag, "_busy"},   {31'd0, busy},      32'd0);
        check({tag, "_ready"},  {31'd0, in_ready},  32'd0);
        check({tag, "_writes"}, we_count - we_base, writes);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        #1;
        check_reset_outputs("por");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // IDLE ignores offered bytes.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(negedge clock);
        @(negedge clock);
        check("idle_ready", {31'd0, in_ready}, 32'd0);
        check("idle_busy",  {31'd0, busy},     32'd0);
        in_valid = 1'b0;

        // Two-word program, back to back.
        we_base = we_count;
        pulse_start();
        check("start_ready",  {31'd0, in_ready},  32'd1);
        check("start_busy",   {31'd0, busy},      32'd1);
        check("start_cpurst", {31'd0, cpu_reset}, 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(8'h00, 32'h20080005, 0);
        send_word(8'h01, 32'h01095020, 0);
        @(negedge clock);
        check_done("b2b", 2);

        // Same program with 3 idle cycles between every byte (reload from DONE).
        we_base = we_count;
        pulse_start();
        check("reload_cpurst", {31'd0, cpu_reset}, 32'd1);
        check("reload_done",   {31'd0, done},      32'd0);
        send_byte(8'h00, 3);
        send_byte(8'h02, 3);
        send_word(8'h00, 32'h20080005, 3);
        send_word(8'h01, 32'h01095020, 3);
        @(negedge clock);
        check_done("gap", 2);

        // Empty program goes straight to DONE.
        we_base = we_count;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_done("n0", 0);

        // N=257 exceeds capacity.
        we_base = we_count;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        #1;
        check("n257_err",    {31'd0, error},     32'd1);
        check("n257_cpurst", {31'd0, cpu_reset}, 32'd1);
        check("n257_busy",   {31'd0, busy},      32'd0);
        check("n257_done",   {31'd0, done},      32'd0);
        check("n257_writes", we_count - we_base, 32'd0);

        // Restart from ERR clears error; full 256-word load.
        @(negedge clock);
        we_base = we_count;
        pulse_start();
        check("err_clear", {31'd0, error}, 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            send_word(i[7:0], {i[7:0], ~i[7:0], 8'hA5, i[7:0]}, 0);
        end
        check("full_last_addr", {24'd0, imem_addr}, 32'h000000FF);
        @(negedge clock);
        check_done("full", 256);

        // Reset during WRITE drops the strobe immediately.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(8'h00, 32'hCAFEF00D, 0);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_write");
        @(negedge clock);
        reset = 1'b0;

        // Reset after two bytes of word 1, then a clean reload from address 0.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(8'h00, 32'h11223344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        we_base = we_count;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(8'h00, 32'h12345678, 0);
        @(negedge clock);
        check_done("after_rst", 1);

        // Reload from DONE with a single word.
        we_base = we_count;
        pulse_start();
        check("r36_cpurst", {31'd0, cpu_reset}, 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(8'h00, 32'hAABBCCDD, 0);
        @(negedge clock);
        check_done("r36", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width; capacity 2^ADDR_W words.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clock.
REQ-004 start  input  1  one-cycle request to begin a program load.
REQ-005 in_data  input  8  serial program byte.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid and in_ready are both 1.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  word index being written.
REQ-010 imem_wdata  output  32  assembled instruction word.
REQ-011 cpu_reset  output  1  holds the pipeline core (PC, IF/ID..MEM/WB) in reset while 1.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  load completed successfully; core released.
REQ-014 error  output  1  header rejected; core held.

Function
REQ-015 States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR; registered outputs derived from state only (Moore).
REQ-016 IDLE: in_ready=0, cpu_reset=1; start -> LEN_HI, word index and byte count cleared.
REQ-017 Stream format: 16-bit big-endian word count N (LEN_HI byte then LEN_LO byte), then 4*N bytes, each word most-significant byte first (first byte -> bits 31:24).
REQ-018 LEN_HI, LEN_LO, DATA: in_ready=1, busy=1; state advances only on a transfer; in_valid=0 stalls indefinitely with no state change.
REQ-019 On LEN_LO transfer: N=0 -> DONE; N > 2^ADDR_W -> ERR; otherwise -> DATA.
REQ-020 DATA: 2-bit byte counter shifts bytes into a 32-bit assembly register; the 4th transfer -> WRITE, counter wraps to 0.
REQ-021 WRITE: exactly one cycle, in_ready=0, imem_we=1, imem_addr=current word index, imem_wdata=assembled word; index increments; if index+1 == N -> DONE else -> DATA.
REQ-022 Write latency: imem_we asserts in the cycle immediately after the 4th byte transfer of a word.
REQ-023 imem_we SHALL be 0 in every state except WRITE; imem_addr/imem_wdata hold last values outside WRITE.
REQ-024 Word index counts ADDR_W+1 bits internally so N = 2^ADDR_W completes without wrap; imem_addr is its low ADDR_W bits.
REQ-025 DONE: cpu_reset=0, done=1, busy=0, in_ready=0; start -> LEN_HI with cpu_reset=1 in that same next cycle (reload).
REQ-026 ERR: error=1, cpu_reset=1, busy=0, in_ready=0; start -> LEN_HI clearing error.
REQ-027 start is ignored in LEN_HI, LEN_LO, DATA, WRITE; in_valid is ignored whenever in_ready=0 (byte not consumed).
REQ-028 Words already written before an aborting reset remain in memory; no rollback.

Reset
REQ-029 On reset: state IDLE, cpu_reset=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, counters 0.
REQ-030 Reset asserted mid-load (any state, including WRITE) SHALL deassert imem_we asynchronously and discard the partial word.

Verification
REQ-031 Reset, start, bytes 00 02 | 20 08 00 05 | 01 09 50 20 back-to-back -> writes addr0=0x20080005, addr1=0x01095020, each one cycle after 4th byte; then done=1, cpu_reset=0.
REQ-032 Same stream with in_valid deasserted 3 cycles between every byte -> identical writes and final state; no extra imem_we.
REQ-033 Header 00 00 -> DONE directly, zero imem_we pulses; header 01 01 (N=257, ADDR_W=8) -> error=1, cpu_reset=1, no writes.
REQ-034 N=256 full load -> 256 writes, addresses 0..255 in order, last address 0xFF, then done=1.
REQ-035 Reset asserted after 2 data bytes of word 1 -> all outputs at reset values immediately; subsequent start reloads cleanly from address 0.
REQ-036 In DONE, start then new N=1 stream AABBCCDD -> cpu_reset returns to 1 next cycle, single write addr0=0xAABBCCDD, then done=1.
